// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - pushbutton synchroniser, debouncer, press/release strobes and reset stretcher
module key_debounce #(
    parameter int NUM_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int CNT_WIDTH         = 20,
    parameter int ACTIVE_LOW_IN     = 1,
    parameter int RESET_HOLD_CYCLES = 256,
    parameter int RESET_ON_KEY0     = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [NUM_KEYS-1:0] keys_out,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] released,
    output logic                reset_out_n
);
    localparam int HOLD_WIDTH = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [NUM_KEYS-1:0] IDLE_LEVEL =
        (ACTIVE_LOW_IN != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};
    localparam logic PRESS_LEVEL = (ACTIVE_LOW_IN == 0);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_DONE = HOLD_WIDTH'(RESET_HOLD_CYCLES);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(RESET_HOLD_CYCLES - 1);

    // Reset generator states: HOLD keeps the system in reset, RUN releases it.
    localparam logic [0:0] ST_HOLD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [NUM_KEYS-1:0]                sync1;
    logic [NUM_KEYS-1:0]                sync2;
    logic [NUM_KEYS-1:0][CNT_WIDTH-1:0] cnt;
    logic [NUM_KEYS-1:0]                accept;
    logic [NUM_KEYS-1:0]                keys_next;
    logic [NUM_KEYS-1:0]                press_mask;
    logic [HOLD_WIDTH-1:0]              hold_cnt;
    logic [0:0]                         rst_state;
    logic                               key0_cause;

    // Two-flop synchroniser; sync2 is the only view of the raw keys used below.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= keys_in;
            sync2 <= sync1;
        end
    end

    // A key flips once it has disagreed with keys_out for DEBOUNCE_CYCLES evaluations in a row.
    always_comb begin
        accept     = '0;
        keys_next  = keys_out;
        press_mask = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            accept[i]     = (sync2[i] != keys_out[i]) && (cnt[i] == CNT_LAST);
            keys_next[i]  = accept[i] ? sync2[i] : keys_out[i];
            press_mask[i] = (keys_next[i] == PRESS_LEVEL);
        end
    end

    // Per-key stability counters: any agreement with keys_out discards all accumulated credit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if ((sync2[i] == keys_out[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Debounced levels and one-cycle strobes registered on the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keys_out <= IDLE_LEVEL;
            pressed  <= '0;
            released <= '0;
        end else begin
            keys_out <= keys_next;
            pressed  <= accept & press_mask;
            released <= accept & ~press_mask;
        end
    end

    // Key 0 counts as a cause on the edge it is accepted as pressed and through the edge its
    // release is accepted, so the full hold starts only after keys_out[0] is back to idle.
    assign key0_cause = (RESET_ON_KEY0 != 0) &&
                        ((keys_out[0] == PRESS_LEVEL) || (keys_next[0] == PRESS_LEVEL));

    // Reset stretcher: count quiet cycles after the last cause, release after RESET_HOLD_CYCLES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt  <= '0;
            rst_state <= ST_HOLD;
        end else if (key0_cause) begin
            hold_cnt  <= '0;
            rst_state <= ST_HOLD;
        end else if (hold_cnt != HOLD_DONE) begin
            hold_cnt <= hold_cnt + HOLD_WIDTH'(1);
            if (hold_cnt == HOLD_LAST) begin
                rst_state <= ST_RUN;
            end
        end
    end

    assign reset_out_n = (rst_state == ST_RUN);

endmodule
